// File: rtl/holiday_input_conditioner.sv
// holiday_input_conditioner: synchronises, debounces and qualifies the roller's button and switches.
// Optional HOLIDAY_LONG_PRESS_EN builds the long_press hold detector; otherwise long_press is 0.
module holiday_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 2_000_000,
  parameter int SW_STABLE_CYCLES = 2_000_000,
  parameter int LONG_PRESS_CYCLES = 200_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       button_raw,
  input  logic [2:0] switch_raw,
  output logic       button_pulse,
  output logic       button_level,
  output logic [2:0] switch_stable,
  output logic       switch_changed,
  output logic       long_press
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int SW = $clog2(SW_STABLE_CYCLES) + 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] SW_LAST = SW'(SW_STABLE_CYCLES - 1);
  if (DEBOUNCE_CYCLES < 2 || SW_STABLE_CYCLES < 2 || LONG_PRESS_CYCLES < 2) begin : g_bad_param
    $error("holiday_input_conditioner: cycle parameters must be >= 2");
  end
  typedef enum logic [1:0] {RELEASED, PRESS_CHK, PRESSED, RELEASE_CHK} state_t;
  state_t state;
  logic [1:0] btn_q;
  logic [2:0] sw_q1, sw_s, candidate;
  logic [DW-1:0] cnt;
  logic [SW-1:0] scnt;
  logic btn_s;
  assign btn_s = btn_q[1];
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_q <= '0;
      state <= RELEASED;
      cnt <= '0;
      button_pulse <= 1'b0;
      button_level <= 1'b0;
    end else begin
      btn_q <= {btn_q[0], button_raw};
      button_pulse <= 1'b0;
      case (state)
        RELEASED: if (btn_s) begin
          state <= PRESS_CHK;
          cnt <= '0;
        end
        PRESS_CHK: if (!btn_s) begin
          state <= RELEASED;
          cnt <= '0;
        end else if (cnt == DB_LAST) begin
          state <= PRESSED;
          cnt <= '0;
          button_pulse <= 1'b1;
          button_level <= 1'b1;
        end else cnt <= cnt + 1'b1;
        PRESSED: if (!btn_s) begin
          state <= RELEASE_CHK;
          cnt <= '0;
        end
        RELEASE_CHK: if (btn_s) begin
          state <= PRESSED;
          cnt <= '0;
        end else if (cnt == DB_LAST) begin
          state <= RELEASED;
          cnt <= '0;
          button_level <= 1'b0;
        end else cnt <= cnt + 1'b1;
        default: state <= RELEASED;
      endcase
    end
  end
  // one shared qualification counter: any bit change restarts the whole bus
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_q1 <= '0;
      sw_s <= '0;
      candidate <= '0;
      scnt <= '0;
      switch_stable <= '0;
      switch_changed <= 1'b0;
    end else begin
      sw_q1 <= switch_raw;
      sw_s <= sw_q1;
      switch_changed <= 1'b0;
      if (sw_s != candidate) begin
        candidate <= sw_s;
        scnt <= '0;
      end else if (scnt != SW_LAST) scnt <= scnt + 1'b1;
      else if (candidate != switch_stable) begin
        switch_stable <= candidate;
        switch_changed <= 1'b1;
      end
    end
  end
`ifdef HOLIDAY_LONG_PRESS_EN
  localparam int LW = $clog2(LONG_PRESS_CYCLES) + 1;
  localparam logic [LW-1:0] LP_LAST = LW'(LONG_PRESS_CYCLES - 1);
  logic [LW-1:0] hcnt;
  // hcnt parks at LP_LAST+1 so the pulse fires once per press
  always_ff @(posedge clk) begin
    if (rst || state != PRESSED) begin
      hcnt <= '0;
      long_press <= 1'b0;
    end else begin
      long_press <= hcnt == LP_LAST;
      hcnt <= hcnt + LW'(hcnt <= LP_LAST);
    end
  end
`else
  assign long_press = 1'b0;
`endif
endmodule

// File: tb/tb_holiday_input_conditioner.sv
// tb_holiday_input_conditioner: scoreboard bench; stimulus queues expected pulses, a monitor pops them.
module tb_holiday_input_conditioner;
  logic clk = 1'b0;
  logic rst, button_raw;
  logic [2:0] switch_raw;
  logic button_pulse, button_level, switch_changed, long_press;
  logic [2:0] switch_stable;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int exp_bp[$];
  int exp_lp[$];
  int exp_sw_cyc[$];
  int exp_sw_val[$];

  holiday_input_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .SW_STABLE_CYCLES(5),
    .LONG_PRESS_CYCLES(10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .button_raw(button_raw),
    .switch_raw(switch_raw),
    .button_pulse(button_pulse),
    .button_level(button_level),
    .switch_stable(switch_stable),
    .switch_changed(switch_changed),
    .long_press(long_press)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got unexpected pulse expected none (cycle %0d)", name, cyc);
  endtask

  task automatic reset_outputs(input string name);
    chk({name, "_pulse"}, button_pulse, 0);
    chk({name, "_level"}, button_level, 0);
    chk({name, "_stable"}, switch_stable, 0);
    chk({name, "_changed"}, switch_changed, 0);
    chk({name, "_long"}, long_press, 0);
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (button_pulse) begin
      if (exp_bp.size() == 0) unexpected("button_pulse");
      else chk("button_pulse_cycle", cyc, exp_bp.pop_front());
    end
    if (long_press) begin
      if (exp_lp.size() == 0) unexpected("long_press");
      else chk("long_press_cycle", cyc, exp_lp.pop_front());
    end
    if (switch_changed) begin
      if (exp_sw_cyc.size() == 0) unexpected("switch_changed");
      else begin
        chk("switch_changed_cycle", cyc, exp_sw_cyc.pop_front());
        chk("switch_stable_value", int'(switch_stable), exp_sw_val.pop_front());
      end
    end
  end

  initial begin
    int c;
    rst = 1'b1;
    button_raw = 1'b1;
    switch_raw = 3'b101;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      reset_outputs("reset_hold");
    end
    // button held through reset is a fresh press; switches publish too
    rst = 1'b0;
    c = cyc;
    exp_bp.push_back(c + 7);
    exp_sw_cyc.push_back(c + 8);
    exp_sw_val.push_back(3'b101);
    wait_n(12);
    chk("t1_level_held", button_level, 1);
    button_raw = 1'b0;
    wait_n(6);
    chk("t1_level_before_release", button_level, 1);
    wait_n(1);
    chk("t1_level_released", button_level, 0);
    wait_n(3);
    // clean press and release timing
    c = cyc;
    button_raw = 1'b1;
    exp_bp.push_back(c + 7);
`ifdef HOLIDAY_LONG_PRESS_EN
    exp_lp.push_back(c + 17);
`endif
    wait_n(6);
    chk("t2_level_before_press", button_level, 0);
    wait_n(1);
    chk("t2_level_pressed", button_level, 1);
    wait_n(13);
    button_raw = 1'b0;
    wait_n(6);
    chk("t2_level_before_release", button_level, 1);
    wait_n(1);
    chk("t2_level_released", button_level, 0);
    wait_n(3);
    // bounce 1,0,1,0,1 then steady high
    c = cyc;
    for (int i = 0; i < 5; i++) begin
      button_raw = (i % 2 == 0);
      wait_n(1);
    end
    exp_bp.push_back(c + 11);
    wait_n(5);
    chk("t3_level_before_press", button_level, 0);
    wait_n(1);
    chk("t3_level_pressed", button_level, 1);
    wait_n(2);
    button_raw = 1'b0;
    wait_n(10);
    // switches back to 000, then 011 with a bit0 toggle
    c = cyc;
    switch_raw = 3'b000;
    exp_sw_cyc.push_back(c + 8);
    exp_sw_val.push_back(3'b000);
    wait_n(12);
    c = cyc;
    switch_raw = 3'b011;
    wait_n(3);
    switch_raw = 3'b010;
    wait_n(1);
    switch_raw = 3'b011;
    exp_sw_cyc.push_back(c + 12);
    exp_sw_val.push_back(3'b011);
    wait_n(7);
    chk("t4_stable_before_publish", switch_stable, 3'b000);
    wait_n(8);
    chk("t4_stable_published", switch_stable, 3'b011);
    switch_raw = 3'b000;
    wait_n(2);
    switch_raw = 3'b011;
    wait_n(15);
    chk("t4_stable_after_short_change", switch_stable, 3'b011);
    // long hold, then a hold with a one-cycle release bounce
    c = cyc;
    button_raw = 1'b1;
    exp_bp.push_back(c + 7);
`ifdef HOLIDAY_LONG_PRESS_EN
    exp_lp.push_back(c + 17);
`endif
    wait_n(30);
    chk("t5_level_long_hold", button_level, 1);
    button_raw = 1'b0;
    wait_n(10);
    c = cyc;
    button_raw = 1'b1;
    exp_bp.push_back(c + 7);
    wait_n(10);
    button_raw = 1'b0;
    wait_n(1);
    button_raw = 1'b1;
`ifdef HOLIDAY_LONG_PRESS_EN
    exp_lp.push_back(c + 24);
`endif
    wait_n(3);
    chk("t5_level_through_bounce", button_level, 1);
    wait_n(21);
    button_raw = 1'b0;
    wait_n(10);
    // reset in PRESS_CHK with cnt=2 aborts the press
    c = cyc;
    button_raw = 1'b1;
    wait_n(5);
    rst = 1'b1;
    button_raw = 1'b0;
    switch_raw = 3'b000;
    wait_n(1);
    reset_outputs("t6_reset");
    wait_n(1);
    rst = 1'b0;
    wait_n(20);
    chk("t6_level_after", button_level, 0);
    chk("t6_stable_after", switch_stable, 3'b000);
    wait_n(5);
    chk("missing_button_pulse", exp_bp.size(), 0);
    chk("missing_long_press", exp_lp.size(), 0);
    chk("missing_switch_changed", exp_sw_cyc.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
